// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, port ids and bus defaults.
package mem_arbiter_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_ACK   = 2'd3;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, debug port and memory-macro side of the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned AW = mem_arbiter_pkg::AW_DEF,
    parameter int unsigned DW = mem_arbiter_pkg::DW_DEF
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_ack;
    logic [DW-1:0] c_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;
    logic          owner;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output busy, owner
    );

    // Requesters plus memory macro side
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  busy, owner
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way grant pick: a lone request wins outright; a tie goes round-robin or to C.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,     // [0] = port C, [1] = port D
    input  logic       last,
    input  logic       fair,
    output logic       gnt_id
);

    always_comb begin
        gnt_id = PORT_C;
        if (req == 2'b10) begin
            gnt_id = PORT_D;
        end else if ((req == 2'b11) && fair) begin
            gnt_id = ~last;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and debug accesses onto a single-ported memory with fixed read latency.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned FAIR    = 1
) (
    input logic         clk,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CW      = $clog2(MEM_LAT + 1);
    localparam logic        FAIR_EN = (FAIR != 0);

    generate
        if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_lat_check
            $error("mem_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
        end
    endgenerate

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          owner_q,   owner_d;
    logic          last_q,    last_d;
    logic          m_en_q,    m_en_d;
    logic          m_we_q,    m_we_d;
    logic [AW-1:0] m_addr_q,  m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          c_ack_q,   c_ack_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic          d_ack_q,   d_ack_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q,    busy_d;
    logic          gnt_id;

    rr_pick2 u_pick (
        .req    ({bus.d_req, bus.c_req}),
        .last   (last_q),
        .fair   (FAIR_EN),
        .gnt_id (gnt_id)
    );

    // State and all output registers; last_q resets to D so C wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            last_q    <= PORT_D;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_ack_q   <= 1'b0;
            c_rdata_q <= '0;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            c_ack_q   <= c_ack_d;
            c_rdata_q <= c_rdata_d;
            d_ack_q   <= d_ack_d;
            d_rdata_q <= d_rdata_d;
            busy_q    <= busy_d;
        end
    end

    // Next state and next register values; the command is frozen at grant time
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        m_en_d    = 1'b0;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        c_ack_d   = 1'b0;
        c_rdata_d = c_rdata_q;
        d_ack_d   = 1'b0;
        d_rdata_d = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (bus.c_req || bus.d_req) begin
                    owner_d = gnt_id;
                    last_d  = gnt_id;
                    m_en_d  = 1'b1;
                    if (gnt_id == PORT_D) begin
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        m_we_d    = bus.c_we;
                        m_addr_d  = bus.c_addr;
                        m_wdata_d = bus.c_wdata;
                    end
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                m_we_d  = 1'b0;
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == PORT_D) begin
                        d_rdata_d = bus.m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        c_rdata_d = bus.m_rdata;
                        c_ack_d   = 1'b1;
                    end
                    state_d = ARB_ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.c_ack   = c_ack_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: three arbiters (LAT1/fair, LAT1/fixed, LAT4/fair), each with a behavioural memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        port;
        logic        chk_data;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q [3][$];

    logic        c_req [3];
    logic        c_we [3];
    logic [31:0] c_addr [3];
    logic [31:0] c_wdata [3];
    logic        d_req [3];
    logic        d_we [3];
    logic [31:0] d_addr [3];
    logic [31:0] d_wdata [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 2) ? 4 : 1;
        localparam int unsigned FR  = (g == 1) ? 0 : 1;

        mem_arbiter_if #(.AW(32), .DW(32)) bus ();

        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .FAIR(FR)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.c_req   = c_req[g];
        assign bus.c_we    = c_we[g];
        assign bus.c_addr  = c_addr[g];
        assign bus.c_wdata = c_wdata[g];
        assign bus.d_req   = d_req[g];
        assign bus.d_we    = d_we[g];
        assign bus.d_addr  = d_addr[g];
        assign bus.d_wdata = d_wdata[g];

        logic [5:0]   flags;
        logic [127:0] words;
        assign flags = {bus.c_ack, bus.d_ack, bus.m_en, bus.m_we, bus.busy, bus.owner};
        assign words = {bus.c_rdata, bus.d_rdata, bus.m_addr, bus.m_wdata};

        // Memory: read data appears LAT cycles after the strobe, garbage otherwise
        logic [31:0] mem [512];
        logic [31:0] pipe [LAT];
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[9'h040] <= 32'hDEAD_BEEF;
                for (int k = 0; k < int'(LAT); k++) pipe[k] <= '0;
            end else begin
                if (bus.m_en && bus.m_we) mem[bus.m_addr[8:0]] <= bus.m_wdata;
                pipe[0] <= (bus.m_en && !bus.m_we) ? mem[bus.m_addr[8:0]] : (32'hBAD0_0000 + cyc);
                for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
            end
        end
        assign bus.m_rdata = pipe[LAT-1];

        always @(negedge clk) begin : mon
            exp_t e;
            if (rst_n && (bus.c_ack || bus.d_ack)) begin
                if (exp_q[g].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL inst%0d unexpected_ack: c_ack=%b d_ack=%b at cycle %0d, required none",
                             g, bus.c_ack, bus.d_ack, cyc);
                end else begin
                    e = exp_q[g].pop_front();
                    chk($sformatf("inst%0d ack_port", g), 128'({bus.d_ack, bus.c_ack}),
                        e.port ? 128'd2 : 128'd1);
                    chk($sformatf("inst%0d ack_cycle", g), 128'(cyc), 128'(e.cyc));
                    chk($sformatf("inst%0d owner_at_ack", g), 128'(bus.owner), 128'(e.port));
                    if (e.chk_data)
                        chk($sformatf("inst%0d rdata", g),
                            128'(e.port ? bus.d_rdata : bus.c_rdata), 128'(e.data));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic p, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (p == PORT_D) begin
            d_req[i] = req; d_we[i] = we; d_addr[i] = addr; d_wdata[i] = wdata;
        end else begin
            c_req[i] = req; c_we[i] = we; c_addr[i] = addr; c_wdata[i] = wdata;
        end
    endtask

    task automatic push(input int i, input logic p, input logic chk_data,
                        input logic [31:0] data, input int unsigned at);
        exp_t e;
        e.port = p; e.chk_data = chk_data; e.data = data; e.cyc = at;
        exp_q[i].push_back(e);
    endtask

    function automatic logic get_ack(input int i, input logic p);
        case (i)
            0:       return p ? g_dut[0].bus.d_ack : g_dut[0].bus.c_ack;
            1:       return p ? g_dut[1].bus.d_ack : g_dut[1].bus.c_ack;
            default: return p ? g_dut[2].bus.d_ack : g_dut[2].bus.c_ack;
        endcase
    endfunction

    function automatic logic [5:0] get_flags(input int i);
        case (i)
            0:       return g_dut[0].flags;
            1:       return g_dut[1].flags;
            default: return g_dut[2].flags;
        endcase
    endfunction

    function automatic logic [127:0] get_words(input int i);
        case (i)
            0:       return g_dut[0].words;
            1:       return g_dut[1].words;
            default: return g_dut[2].words;
        endcase
    endfunction

    // Returns in the ack cycle, or after the budget with a failed check
    task automatic wait_ack(input int i, input logic p, input int budget);
        int n = 0;
        while (!get_ack(i, p) && n < budget) begin
            step(1);
            n++;
        end
        chk($sformatf("inst%0d ack_seen_port%0d", i, p), 128'(get_ack(i, p)), 128'd1);
    endtask

    initial begin : stim
        int unsigned t0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(i, PORT_C, 1'b0, 1'b0, '0, '0);
            set_cmd(i, PORT_D, 1'b0, 1'b0, '0, '0);
        end
        step(2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("inst%0d reset_flags", i), 128'(get_flags(i)), 128'd0);
            chk($sformatf("inst%0d reset_words", i), get_words(i), 128'd0);
        end
        rst_n = 1'b1;
        step(1);

        // C read of preloaded word, LAT=1
        t0 = cyc;
        set_cmd(0, PORT_C, 1'b1, 1'b0, 32'h40, '0);
        push(0, PORT_C, 1'b1, 32'hDEAD_BEEF, t0 + 3);
        step(1);
        chk("t1 m_en", 128'(g_dut[0].bus.m_en), 128'd1);
        chk("t1 m_addr", 128'(g_dut[0].bus.m_addr), 128'h40);
        chk("t1 m_we", 128'(g_dut[0].bus.m_we), 128'd0);
        chk("t1 busy", 128'(g_dut[0].bus.busy), 128'd1);
        wait_ack(0, PORT_C, 8);
        chk("t1 d_rdata_hold", 128'(g_dut[0].bus.d_rdata), 128'd0);
        step(1);
        set_cmd(0, PORT_C, 1'b0, 1'b0, '0, '0);
        chk("t1 idle_after_ack", 128'({g_dut[0].bus.busy, g_dut[0].bus.c_ack}), 128'd0);

        // D write then C read-back
        t0 = cyc;
        set_cmd(0, PORT_D, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        push(0, PORT_D, 1'b0, '0, t0 + 3);
        step(1);
        chk("t2 issue_flags", 128'({g_dut[0].bus.m_en, g_dut[0].bus.m_we, g_dut[0].bus.owner}), 128'b111);
        chk("t2 m_addr", 128'(g_dut[0].bus.m_addr), 128'h100);
        chk("t2 m_wdata", 128'(g_dut[0].bus.m_wdata), 128'h1234_5678);
        step(1);
        chk("t2 wait_flags", 128'({g_dut[0].bus.m_en, g_dut[0].bus.m_we}), 128'd0);
        wait_ack(0, PORT_D, 8);
        step(1);
        set_cmd(0, PORT_D, 1'b0, 1'b0, '0, '0);
        t0 = cyc;
        set_cmd(0, PORT_C, 1'b1, 1'b0, 32'h100, '0);
        push(0, PORT_C, 1'b1, 32'h1234_5678, t0 + 3);
        step(1);
        chk("t2 read_issue", 128'({g_dut[0].bus.m_en, g_dut[0].bus.m_we}), 128'b10);
        wait_ack(0, PORT_C, 8);
        step(1);
        set_cmd(0, PORT_C, 1'b0, 1'b0, '0, '0);
        step(1);

        // Both ports held from reset: fair alternates, fixed always serves C
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_cmd(i, PORT_C, 1'b1, 1'b0, 32'h40, '0);
            set_cmd(i, PORT_D, 1'b1, 1'b1, 32'h44, 32'hA5A5_0001);
        end
        step(1);
        rst_n = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            push(0, 1'(k % 2), (k % 2) == 0, 32'hDEAD_BEEF, t0 + 3 + 4 * k);
            push(1, PORT_C, 1'b1, 32'hDEAD_BEEF, t0 + 3 + 4 * k);
        end
        step(16);
        for (int i = 0; i < 2; i++) begin
            set_cmd(i, PORT_C, 1'b0, 1'b0, '0, '0);
            set_cmd(i, PORT_D, 1'b0, 1'b0, '0, '0);
        end
        chk("t3 fair_last_owner", 128'(g_dut[0].bus.owner), 128'(PORT_D));
        chk("t3 fixed_last_owner", 128'(g_dut[1].bus.owner), 128'(PORT_C));
        step(2);

        // LAT=4: command and D request change during WAIT are ignored until IDLE
        t0 = cyc;
        set_cmd(2, PORT_C, 1'b1, 1'b0, 32'h40, '0);
        push(2, PORT_C, 1'b1, 32'hDEAD_BEEF, t0 + 6);
        step(2);
        set_cmd(2, PORT_C, 1'b1, 1'b0, 32'h44, '0);
        set_cmd(2, PORT_D, 1'b1, 1'b0, 32'h40, '0);
        push(2, PORT_D, 1'b1, 32'hDEAD_BEEF, t0 + 13);
        step(1);
        chk("t4 m_addr_frozen", 128'(g_dut[2].bus.m_addr), 128'h40);
        wait_ack(2, PORT_C, 12);
        step(1);
        set_cmd(2, PORT_C, 1'b0, 1'b0, '0, '0);
        wait_ack(2, PORT_D, 12);
        step(1);
        set_cmd(2, PORT_D, 1'b0, 1'b0, '0, '0);
        step(1);

        // Reset during WAIT abandons the access
        set_cmd(2, PORT_C, 1'b1, 1'b0, 32'h40, '0);
        step(3);
        chk("t5 busy_before_reset", 128'(g_dut[2].bus.busy), 128'd1);
        rst_n = 1'b0;
        set_cmd(2, PORT_C, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t5 reset_flags", 128'(get_flags(2)), 128'd0);
        chk("t5 reset_words", get_words(2), 128'd0);
        step(1);
        rst_n = 1'b1;
        step(8);
        t0 = cyc;
        set_cmd(2, PORT_C, 1'b1, 1'b0, 32'h40, '0);
        push(2, PORT_C, 1'b1, 32'hDEAD_BEEF, t0 + 6);
        wait_ack(2, PORT_C, 12);
        step(1);
        set_cmd(2, PORT_C, 1'b0, 1'b0, '0, '0);
        step(3);

        for (int i = 0; i < 3; i++)
            chk($sformatf("inst%0d pending_expected", i), 128'(exp_q[i].size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
